// File: rtl/frm_pkg.sv
// Shared frame-reply types: sequencer state encoding, word geometry, word-count clamp.
// Combinational only; no latency, no backpressure.
package frm_pkg;

    localparam int WORD_BITS = 16;
    localparam int BIT_CNT_W = $clog2(WORD_BITS);
    localparam int WORDS_W   = 6;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_DATA     = 3'd3,
        ST_TAIL     = 3'd4,
        ST_DONE     = 3'd5
    } rpy_state_t;

    function automatic logic [WORDS_W-1:0] clamp_words(input logic [WORDS_W-1:0] words,
                                                       input logic [WORDS_W-1:0] max_words);
        return (words > max_words) ? max_words : words;
    endfunction

endpackage

// File: rtl/reply_sequencer_if.sv
// Request, reply-memory, frame-generator and reply-stream signals of the reply sequencer.
// Wiring only; the master modport is the surrounding system, the slave modport is the sequencer.
interface reply_sequencer_if #(
    parameter int ADDR_W = 6
) ();
    import frm_pkg::*;

    logic                rpy_req;
    logic                rpy_crc;
    logic [ADDR_W-1:0]   rpy_base;
    logic [WORDS_W-1:0]  rpy_words;

    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    word_t               mem_rdata;

    logic                pre_p_complete;
    logic                p_complete;
    logic                fg_complete;

    logic                reply_data;
    logic                reply_complete;
    logic                en_crc16_for_rpy;
    logic                crc_en;
    logic                busy;
    logic                done;

    modport master (
        output rpy_req, rpy_crc, rpy_base, rpy_words, mem_rdata,
               pre_p_complete, p_complete, fg_complete,
        input  mem_rd, mem_addr, reply_data, reply_complete,
               en_crc16_for_rpy, crc_en, busy, done
    );

    modport slave (
        input  rpy_req, rpy_crc, rpy_base, rpy_words, mem_rdata,
               pre_p_complete, p_complete, fg_complete,
        output mem_rd, mem_addr, reply_data, reply_complete,
               en_crc16_for_rpy, crc_en, busy, done
    );

endinterface

// File: rtl/reply_shifter.sv
// 16-bit load/shift register presenting its MSB, with a count of bits shifted since the last load.
// Load/shift take effect on the next clk_frm edge; load wins over shift; no backpressure.
module reply_shifter
    import frm_pkg::*;
(
    input  logic                 clk_frm,
    input  logic                 rst_for_new_package,
    input  logic                 load_en,
    input  logic                 shift_en,
    input  word_t                load_dat,
    output logic                 msb,
    output logic [BIT_CNT_W-1:0] bit_cnt
);

    word_t sr_q;

    always_ff @(posedge clk_frm or negedge rst_for_new_package) begin
        if (!rst_for_new_package) begin
            sr_q    <= '0;
            bit_cnt <= '0;
        end else if (load_en) begin
            sr_q    <= load_dat;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sr_q    <= {sr_q[WORD_BITS-2:0], 1'b0};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end
    end

    assign msb = sr_q[WORD_BITS-1];

endmodule

// File: rtl/reply_sequencer.sv
// Fetches reply words from memory and serialises them MSB-first into the frame generator.
// First bit on the first p_complete cycle, one bit per clk_frm; no backpressure, pacing comes from p_complete/fg_complete.
module reply_sequencer
    import frm_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int MAX_WORDS = 32
) (
    input  logic             clk_frm,
    input  logic             rst_for_new_package,
    reply_sequencer_if.slave bus
);

    localparam logic [WORDS_W-1:0]   MAX_WORDS_V = WORDS_W'(MAX_WORDS);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST    = BIT_CNT_W'(WORD_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_PREF    = BIT_CNT_W'(WORD_BITS - 2);

    rpy_state_t           state_q, state_d;
    logic                 fetch_ph_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [WORDS_W-1:0]   words_rem_q;
    logic                 crc_q, zero_q, rc_q;

    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 sr_msb;

    logic accept, present, last_bit, more_words, prefetch;
    logic load_first, load_next, proto_err, zero_done, set_rc, mem_rd_c;

    assign accept     = (state_q == ST_IDLE) && bus.rpy_req;
    assign present    = ((state_q == ST_PREAMBLE) && bus.p_complete) || (state_q == ST_DATA);
    assign more_words = words_rem_q > WORDS_W'(1);
    assign last_bit   = present && (bit_cnt == BIT_LAST);
    // Next word is read two bits early so it lands exactly as the current word's last bit leaves.
    assign prefetch   = present && (bit_cnt == BIT_PREF) && more_words;
    assign load_first = (state_q == ST_FETCH) && fetch_ph_q;
    assign load_next  = last_bit && more_words;
    assign proto_err  = (state_q == ST_FETCH) && bus.p_complete;
    assign zero_done  = (state_q == ST_TAIL) && zero_q && bus.p_complete;
    assign set_rc     = (last_bit && !more_words) || proto_err || zero_done ||
                        ((state_q == ST_TAIL) && zero_q && bus.pre_p_complete);

    always_ff @(posedge clk_frm or negedge rst_for_new_package) begin
        if (!rst_for_new_package) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.rpy_req) state_d = (bus.rpy_words == '0) ? ST_TAIL : ST_FETCH;
            ST_FETCH: begin
                if (bus.p_complete)  state_d = ST_TAIL;
                else if (fetch_ph_q) state_d = ST_PREAMBLE;
            end
            ST_PREAMBLE: if (bus.p_complete) state_d = ST_DATA;
            ST_DATA:     if (last_bit && !more_words) state_d = ST_TAIL;
            ST_TAIL:     if (bus.fg_complete) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_rd_c             = ((state_q == ST_FETCH) && !fetch_ph_q) || prefetch;
        bus.mem_rd           = mem_rd_c;
        bus.mem_addr         = addr_q;
        bus.reply_data       = ((state_q == ST_PREAMBLE) || (state_q == ST_DATA)) ? sr_msb : 1'b0;
        bus.crc_en           = present;
        bus.reply_complete   = rc_q || zero_done;
        bus.en_crc16_for_rpy = crc_q;
        bus.busy             = (state_q != ST_IDLE);
        bus.done             = (state_q == ST_DONE);
    end

    always_ff @(posedge clk_frm or negedge rst_for_new_package) begin
        if (!rst_for_new_package) begin
            fetch_ph_q  <= 1'b0;
            addr_q      <= '0;
            words_rem_q <= '0;
            crc_q       <= 1'b0;
            zero_q      <= 1'b0;
            rc_q        <= 1'b0;
        end else begin
            // FETCH spends one cycle issuing the read and one cycle loading the returned word.
            fetch_ph_q <= (state_q == ST_FETCH) && !fetch_ph_q;
            if (accept) begin
                addr_q      <= bus.rpy_base;
                words_rem_q <= clamp_words(bus.rpy_words, MAX_WORDS_V);
                crc_q       <= bus.rpy_crc;
                zero_q      <= (bus.rpy_words == '0);
            end else begin
                if (mem_rd_c)  addr_q      <= addr_q + ADDR_W'(1);
                if (load_next) words_rem_q <= words_rem_q - WORDS_W'(1);
            end
            if (set_rc) rc_q <= 1'b1;
        end
    end

    reply_shifter u_shifter (
        .clk_frm             (clk_frm),
        .rst_for_new_package (rst_for_new_package),
        .load_en             (load_first || load_next),
        .shift_en            (present && !load_next),
        .load_dat            (bus.mem_rdata),
        .msb                 (sr_msb),
        .bit_cnt             (bit_cnt)
    );

endmodule

// File: tb/tb_reply_sequencer.sv
// Scoreboarded bench for reply_sequencer: expected addresses/bits queued per request, popped on mem_rd/crc_en.
module tb_reply_sequencer;
    import frm_pkg::*;

    localparam int ADDR_W    = 6;
    localparam int MAX_WORDS = 32;

    logic clk_frm = 1'b0;
    logic rst_for_new_package = 1'b0;
    always #5 clk_frm = ~clk_frm;

    reply_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    reply_sequencer #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk_frm             (clk_frm),
        .rst_for_new_package (rst_for_new_package),
        .bus                 (bus)
    );

    word_t mem [64];
    always @(posedge clk_frm) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int crc_cnt, first_cyc, last_cyc, pc_cyc, rc_cyc, done_cnt, rd_cnt;
    logic [ADDR_W-1:0] exp_addr [$];
    logic              exp_bits [$];

    always @(posedge clk_frm) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk_frm) begin
        if (rst_for_new_package) begin
            if (bus.mem_rd) begin
                rd_cnt++;
                if (exp_addr.size() == 0) chk("unexpected_rd", 32'(bus.mem_addr), 32'hFFFF);
                else                      chk("rd_addr", 32'(bus.mem_addr), 32'(exp_addr.pop_front()));
            end
            if (bus.crc_en) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                crc_cnt++;
                if (exp_bits.size() == 0) chk("extra_bit", 32'(bus.reply_data), 32'h2);
                else                      chk("bit", 32'(bus.reply_data), 32'(exp_bits.pop_front()));
            end
            if (bus.p_complete && pc_cyc < 0)     pc_cyc = cyc;
            if (bus.reply_complete && rc_cyc < 0) rc_cyc = cyc;
            if (bus.done) done_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_frm);
        #1;
    endtask

    task automatic clear_stats();
        crc_cnt = 0; first_cyc = -1; last_cyc = -1; pc_cyc = -1;
        rc_cyc = -1; done_cnt = 0; rd_cnt = 0;
        exp_addr.delete();
        exp_bits.delete();
    endtask

    function automatic int eff_words(input logic [5:0] words);
        return (int'(words) > MAX_WORDS) ? MAX_WORDS : int'(words);
    endfunction

    task automatic push_expect(input logic [5:0] base, input logic [5:0] words);
        logic [ADDR_W-1:0] a;
        for (int w = 0; w < eff_words(words); w++) begin
            a = base + ADDR_W'(w);
            exp_addr.push_back(a);
            for (int b = 15; b >= 0; b--) exp_bits.push_back(mem[a][b]);
        end
    endtask

    task automatic send_req(input logic [5:0] base, input logic [5:0] words, input logic crc);
        bus.rpy_req = 1'b1; bus.rpy_base = base; bus.rpy_words = words; bus.rpy_crc = crc;
        tick();
        bus.rpy_req = 1'b0;
    endtask

    task automatic start_frame();
        tick(6);
        bus.pre_p_complete = 1'b1;
        tick();
        bus.pre_p_complete = 1'b0;
        bus.p_complete = 1'b1;
    endtask

    task automatic do_reset();
        rst_for_new_package = 1'b0;
        bus.rpy_req = 1'b0; bus.pre_p_complete = 1'b0; bus.p_complete = 1'b0; bus.fg_complete = 1'b0;
        tick(2);
        rst_for_new_package = 1'b1;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(bus.busy), 0);
        chk({tag, "_done"},      32'(bus.done), 0);
        chk({tag, "_mem_rd"},    32'(bus.mem_rd), 0);
        chk({tag, "_mem_addr"},  32'(bus.mem_addr), 0);
        chk({tag, "_crc_en"},    32'(bus.crc_en), 0);
        chk({tag, "_data"},      32'(bus.reply_data), 0);
        chk({tag, "_complete"},  32'(bus.reply_complete), 0);
        chk({tag, "_en_crc16"},  32'(bus.en_crc16_for_rpy), 0);
    endtask

    task automatic run_reply(input string name, input logic [5:0] base, input logic [5:0] words,
                             input logic crc, input bit re_req);
        int eff;
        int n;
        eff = eff_words(words);
        clear_stats();
        push_expect(base, words);
        send_req(base, words, crc);
        start_frame();
        if (re_req) begin
            tick(10);
            send_req(~base, 6'd5, ~crc);
        end
        n = 0;
        while (!bus.reply_complete && n < 16 * eff + 40) begin tick(); n++; end
        if (!bus.reply_complete) chk({name, "_rc_timeout"}, 0, 1);
        tick(3);
        chk({name, "_crc_cnt"}, crc_cnt, 16 * eff);
        chk({name, "_rd_cnt"}, rd_cnt, eff);
        chk({name, "_bits_left"}, exp_bits.size(), 0);
        chk({name, "_addr_left"}, exp_addr.size(), 0);
        if (eff > 0) begin
            chk({name, "_first_bit_cyc"}, first_cyc, pc_cyc);
            chk({name, "_contiguous"}, last_cyc - first_cyc + 1, crc_cnt);
            chk({name, "_rc_cyc"}, rc_cyc, last_cyc + 1);
        end else begin
            chk({name, "_rc_cyc"}, rc_cyc, pc_cyc);
        end
        chk({name, "_en_crc16"}, 32'(bus.en_crc16_for_rpy), 32'(crc));
        chk({name, "_busy_tail"}, 32'(bus.busy), 1);
        chk({name, "_no_early_done"}, done_cnt, 0);
        bus.fg_complete = 1'b1;
        tick();
        bus.fg_complete = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 10) begin tick(); n++; end
        tick(3);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_busy_after"}, 32'(bus.busy), 0);
        chk({name, "_rc_held"}, 32'(bus.reply_complete), 1);
        bus.p_complete = 1'b0;
    endtask

    initial begin
        bus.rpy_req = 1'b0; bus.rpy_crc = 1'b0; bus.rpy_base = '0; bus.rpy_words = '0;
        bus.pre_p_complete = 1'b0; bus.p_complete = 1'b0; bus.fg_complete = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hA5C3;
        clear_stats();

        tick(2);
        check_reset_outputs("reset");
        rst_for_new_package = 1'b1;
        tick();

        run_reply("one_word", 6'h00, 6'd1, 1'b0, 1'b0);
        do_reset();
        run_reply("wrap", 6'h3E, 6'd3, 1'b0, 1'b0);
        do_reset();
        run_reply("zero", 6'h00, 6'd0, 1'b1, 1'b0);
        do_reset();
        run_reply("rereq", 6'h20, 6'd2, 1'b0, 1'b1);
        do_reset();
        run_reply("clamp", 6'h10, 6'd40, 1'b1, 1'b0);
        do_reset();

        // Abort with reset while bit 7 of the second word is on the line.
        clear_stats();
        push_expect(6'h08, 6'd3);
        send_req(6'h08, 6'd3, 1'b1);
        start_frame();
        tick(23);
        #2;
        chk("abort_bits_before", crc_cnt, 23);
        chk("abort_busy_before", 32'(bus.busy), 1);
        rst_for_new_package = 1'b0;
        #1;
        check_reset_outputs("abort");
        tick(2);
        bus.p_complete = 1'b0;
        rst_for_new_package = 1'b1;
        tick(5);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_idle", 32'(bus.busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", n_err);
        $fatal(1);
    end

endmodule

// File: doc/reply_sequencer.md
REPLY_SEQUENCER -- requirements
Module: reply_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, width of the reply-memory word address.
REQ-002 SHALL have parameter MAX_WORDS, default 32, largest accepted rpy_words value.
REQ-003 SHALL have port clk_frm  input  1  frame clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_for_new_package  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rpy_req  input  1  one-cycle pulse starting a reply; ignored unless IDLE.
REQ-006 SHALL have port rpy_crc  input  1  sampled with rpy_req; 1 = append CRC16.
REQ-007 SHALL have port rpy_base  input  ADDR_W  sampled with rpy_req; first word address.
REQ-008 SHALL have port rpy_words  input  6  sampled with rpy_req; number of 16-bit words, 0..MAX_WORDS.
REQ-009 SHALL have port mem_rd  output  1  word read strobe.
REQ-010 SHALL have port mem_addr  output  ADDR_W  read address.
REQ-011 SHALL have port mem_rdata  input  16  read data, valid exactly 1 cycle after mem_rd.
REQ-012 SHALL have port pre_p_complete  input  1  frame generator: preamble ends next cycle.
REQ-013 SHALL have port p_complete  input  1  frame generator: preamble finished, data phase.
REQ-014 SHALL have port fg_complete  input  1  frame generator: data/CRC/EoS accepted.
REQ-015 SHALL have port reply_data  output  1  current reply bit, MSB first.
REQ-016 SHALL have port reply_complete  output  1  all data bits presented; level.
REQ-017 SHALL have port en_crc16_for_rpy  output  1  latched rpy_crc.
REQ-018 SHALL have port crc_en  output  1  one pulse per data bit, for the CRC16 generator.
REQ-019 SHALL have port busy  output  1  high in any state except IDLE.
REQ-020 SHALL have port done  output  1  one-cycle pulse on DONE->IDLE.

Function
REQ-021 SHALL implement states IDLE, FETCH, PREAMBLE, DATA, TAIL, DONE.
REQ-022 IDLE: rpy_req=1 -> latch rpy_crc/rpy_base/rpy_words; go FETCH if rpy_words>0, else TAIL.
REQ-023 FETCH: assert mem_rd for one cycle at rpy_base; load word into 16-bit shift register next cycle; go PREAMBLE.
REQ-024 PREAMBLE: hold reply_data = shift-register MSB; go DATA on first cycle p_complete=1.
REQ-025 reply_data SHALL equal word bit 15 during the first p_complete=1 cycle, advancing one bit per clk_frm.
REQ-026 DATA: crc_en=1 every cycle a bit is presented; 16*rpy_words pulses total.
REQ-027 Prefetch: mem_rd for word n+1 SHALL issue at bit index 14 of word n; no bubble at word boundaries.
REQ-028 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-029 After last bit of last word: reply_complete=1 next cycle, held until reset; go TAIL.
REQ-030 rpy_words=0: reply_complete SHALL assert on first p_complete=1 cycle; crc_en never pulses.
REQ-031 TAIL: wait fg_complete=1 -> DONE; DONE -> IDLE after one cycle, done=1 that cycle.
REQ-032 rpy_req while busy SHALL be ignored, no latch update.
REQ-033 rpy_words>MAX_WORDS SHALL be clamped to MAX_WORDS.
REQ-034 p_complete=1 while in FETCH SHALL be a protocol error: go TAIL, reply_complete=1.

Reset
REQ-035 Reset SHALL force IDLE, reply_data=0, reply_complete=0, en_crc16_for_rpy=0, crc_en=0, mem_rd=0, mem_addr=0, busy=0, done=0, counters 0.
REQ-036 Reset mid-reply SHALL abort immediately; no done pulse.

Structure
REQ-037 State encoding and the WORD_BITS=16 constant SHALL live in shared package frm_pkg.
REQ-038 One sub-module, reply_shifter (16-bit load/shift register with bit counter), SHALL be used.

Verification
REQ-039 rpy_words=1, rpy_crc=0, mem word 16'hA5C3, FM0 preamble -> reply_data 1010010111000011 from first p_complete cycle; reply_complete next cycle; 16 crc_en.
REQ-040 rpy_words=3, base 6'h3E -> addresses 3E,3F,00; 48 contiguous bits, no gap.
REQ-041 rpy_words=0, rpy_crc=1 -> no mem_rd, reply_complete on first p_complete cycle, en_crc16_for_rpy=1.
REQ-042 rpy_req repeated during DATA -> ignored; bitstream unchanged.
REQ-043 Reset asserted at bit 7 of word 2 -> all outputs 0 asynchronously, IDLE, no done.
REQ-044 fg_complete after reply_complete -> done pulses exactly one cycle, busy=0 after.
